// File: rtl/led_breathe_pwm.sv
// rtl/led_breathe_pwm.sv - breathing RGB LED PWM with debounced mode/pause buttons
// Optional square-law duty curve when LED_GAMMA_EN is defined.

module btn_debounce #(
    parameter int CYC = 240000
) (
    input  logic clk,
    input  logic resetn,
    input  logic pin,
    output logic press
);
    localparam int CW = (CYC > 1) ? $clog2(CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYC - 1);

    logic          sync_1;
    logic          sync_2;
    logic          db;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            db     <= 1'b1;
            cnt    <= '0;
        end else begin
            sync_1 <= pin;
            sync_2 <= sync_1;
            if (sync_2 != db) begin
                if (cnt == LAST) begin
                    db  <= sync_2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    // Pulse on the same cycle the debounced level is accepted as pressed.
    assign press = ~sync_2 & db & (cnt == LAST);
endmodule

module led_breathe_pwm #(
    parameter int PWM_BITS     = 8,
    parameter int STEP_DIV     = 46875,
    parameter int DEBOUNCE_CYC = 240000
) (
    input  logic       XTAL_IN,
    input  logic       RST_N,
    input  logic       BTN_A,
    input  logic       BTN_B,
    output logic       LED_R,
    output logic       LED_G,
    output logic       LED_B,
    output logic [2:0] MODE,
    output logic       PAUSED
);
    localparam int SW = $clog2(STEP_DIV);
    localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_DIV - 1);
    localparam logic [PWM_BITS-1:0] MAX       = '1;
    localparam logic [PWM_BITS-1:0] ONE       = PWM_BITS'(1);

    typedef enum logic [2:0] {
        M_RED   = 3'd0,
        M_GREEN = 3'd1,
        M_BLUE  = 3'd2,
        M_WHITE = 3'd3,
        M_CYCLE = 3'd4
    } mode_t;

    typedef enum logic [1:0] {
        SEL_R = 2'd0,
        SEL_G = 2'd1,
        SEL_B = 2'd2
    } sel_t;

    mode_t               mode;
    sel_t                cyc_sel;
    logic [PWM_BITS-1:0] bright;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty;
    logic [SW-1:0]       step_cnt;
    logic                dir_dn;
    logic                paused;
    logic                step_tick;
    logic                press_a;
    logic                press_b;
    logic                mode_bad;
    logic                chan_on;
    logic                en_r;
    logic                en_g;
    logic                en_b;

    btn_debounce #(.CYC(DEBOUNCE_CYC)) u_db_a (
        .clk(XTAL_IN), .resetn(RST_N), .pin(BTN_A), .press(press_a)
    );

    btn_debounce #(.CYC(DEBOUNCE_CYC)) u_db_b (
        .clk(XTAL_IN), .resetn(RST_N), .pin(BTN_B), .press(press_b)
    );

    assign step_tick = (step_cnt == STEP_LAST);
    assign mode_bad  = (mode > M_CYCLE);

    always_ff @(posedge XTAL_IN) begin
        if (!RST_N) begin
            mode     <= M_RED;
            bright   <= '0;
            dir_dn   <= 1'b0;
            step_cnt <= '0;
            cyc_sel  <= SEL_R;
            paused   <= 1'b0;
        end else begin
            if (press_b)
                paused <= ~paused;

            if (step_tick)
                step_cnt <= '0;
            else
                step_cnt <= step_cnt + SW'(1);

            // Uses the pre-toggle pause value, so a step lands only if we were running.
            if (step_tick && !paused) begin
                if (!dir_dn) begin
                    if (bright == MAX) begin
                        bright <= MAX - ONE;
                        dir_dn <= 1'b1;
                    end else begin
                        bright <= bright + ONE;
                    end
                end else begin
                    if (bright == '0) begin
                        bright <= ONE;
                        dir_dn <= 1'b0;
                        case (cyc_sel)
                            SEL_R:   cyc_sel <= SEL_G;
                            SEL_G:   cyc_sel <= SEL_B;
                            default: cyc_sel <= SEL_R;
                        endcase
                    end else begin
                        bright <= bright - ONE;
                    end
                end
            end

            case (mode)
                M_RED:   if (press_a) mode <= M_GREEN;
                M_GREEN: if (press_a) mode <= M_BLUE;
                M_BLUE:  if (press_a) mode <= M_WHITE;
                M_WHITE: if (press_a) mode <= M_CYCLE;
                M_CYCLE: if (press_a) mode <= M_RED;
                default: mode <= M_RED;
            endcase

            // A mode change restarts the ramp and overrides any step this cycle.
            if (press_a || mode_bad) begin
                bright   <= '0;
                dir_dn   <= 1'b0;
                step_cnt <= '0;
                cyc_sel  <= SEL_R;
            end
        end
    end

    always_ff @(posedge XTAL_IN) begin
        if (!RST_N)
            pwm_cnt <= '0;
        else
            pwm_cnt <= pwm_cnt + ONE;
    end

`ifdef LED_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq;
    assign sq   = {{PWM_BITS{1'b0}}, bright} * {{PWM_BITS{1'b0}}, bright};
    assign duty = PWM_BITS'(sq >> PWM_BITS);
`else
    assign duty = bright;
`endif

    assign chan_on = (pwm_cnt < duty);

    always_comb begin
        en_r = 1'b0;
        en_g = 1'b0;
        en_b = 1'b0;
        case (mode)
            M_RED:   en_r = 1'b1;
            M_GREEN: en_g = 1'b1;
            M_BLUE:  en_b = 1'b1;
            M_WHITE: begin
                en_r = 1'b1;
                en_g = 1'b1;
                en_b = 1'b1;
            end
            M_CYCLE: begin
                en_r = (cyc_sel == SEL_R);
                en_g = (cyc_sel == SEL_G);
                en_b = (cyc_sel == SEL_B);
            end
            default: ;
        endcase
    end

    always_ff @(posedge XTAL_IN) begin
        if (!RST_N) begin
            LED_R <= 1'b1;
            LED_G <= 1'b1;
            LED_B <= 1'b1;
        end else begin
            LED_R <= ~(chan_on & en_r);
            LED_G <= ~(chan_on & en_g);
            LED_B <= ~(chan_on & en_b);
        end
    end

    assign MODE   = mode;
    assign PAUSED = paused;
endmodule

// File: tb/tb_led_breathe_pwm.sv
// tb/tb_led_breathe_pwm.sv - randomized directed bench for led_breathe_pwm against a step-count model

module tb_led_breathe_pwm;
    localparam int PB   = 4;
    localparam int SD   = 4;
    localparam int DC   = 8;
    localparam int MAXB = (1 << PB) - 1;
    localparam int PER  = 1 << PB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_a = 1'b1;
    logic       btn_b = 1'b1;
    logic       led_r, led_g, led_b, paused;
    logic [2:0] mode;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Model: brightness is a triangle function of the number of applied steps.
    int       m_pwm, m_phase, m_steps, m_mode, m_cyc;
    bit       m_paused;
    bit [2:0] m_led;
    bit       lag [2][2];
    bit       db [2];
    int       run_len [2];

    always #5 clk = ~clk;

    led_breathe_pwm #(.PWM_BITS(PB), .STEP_DIV(SD), .DEBOUNCE_CYC(DC)) dut (
        .XTAL_IN(clk), .RST_N(rst_n), .BTN_A(btn_a), .BTN_B(btn_b),
        .LED_R(led_r), .LED_G(led_g), .LED_B(led_b), .MODE(mode), .PAUSED(paused)
    );

    function automatic int tri_val(int s);
        int k;
        k = s % (2 * MAXB);
        return (k <= MAXB) ? k : 2 * MAXB - k;
    endfunction

    function automatic int duty_of(int br);
`ifdef LED_GAMMA_EN
        return (br * br) >> PB;
`else
        return br;
`endif
    endfunction

    task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // The pin, seen two clocks late, must differ from the accepted level for DC clocks in a row.
    task automatic btn_model(int i, bit pin, output bit pressed);
        bit late;
        late = lag[i][1];
        pressed = 1'b0;
        if (late != db[i]) run_len[i]++;
        else run_len[i] = 0;
        if (run_len[i] == DC) begin
            db[i] = late;
            run_len[i] = 0;
            pressed = (late == 1'b0);
        end
        lag[i][1] = lag[i][0];
        lag[i][0] = pin;
    endtask

    task automatic model_reset();
        m_pwm = 0; m_phase = 0; m_steps = 0; m_mode = 0; m_cyc = 0;
        m_paused = 1'b0;
        m_led = 3'b111;
        for (int i = 0; i < 2; i++) begin
            lag[i][0] = 1'b1; lag[i][1] = 1'b1; db[i] = 1'b1; run_len[i] = 0;
        end
    endtask

    task automatic model_edge(bit r, bit a, bit b);
        bit on, er, eg, eb, pa, pb, tick;
        if (!r) begin
            model_reset();
            return;
        end
        er = (m_mode == 0) || (m_mode == 3) || (m_mode == 4 && m_cyc == 0);
        eg = (m_mode == 1) || (m_mode == 3) || (m_mode == 4 && m_cyc == 1);
        eb = (m_mode == 2) || (m_mode == 3) || (m_mode == 4 && m_cyc == 2);
        on = (m_pwm < duty_of(tri_val(m_steps)));
        m_led = {~(on & er), ~(on & eg), ~(on & eb)};
        btn_model(0, a, pa);
        btn_model(1, b, pb);
        tick = (m_phase == SD - 1);
        if (pa) begin
            m_mode = (m_mode + 1) % 5;
            m_steps = 0; m_phase = 0; m_cyc = 0;
        end else begin
            m_phase = (m_phase + 1) % SD;
            if (tick && !m_paused) begin
                if (m_steps > 0 && m_steps % (2 * MAXB) == 0) m_cyc = (m_cyc + 1) % 3;
                m_steps++;
            end
        end
        if (pb) m_paused = !m_paused;
        m_pwm = (m_pwm + 1) % PER;
    endtask

    task automatic step();
        bit r, a, b;
        r = rst_n; a = btn_a; b = btn_b;
        @(posedge clk);
        #1;
        model_edge(r, a, b);
        check("state", {1'b0, mode, paused, led_r, led_g, led_b},
              {1'b0, 3'(m_mode), m_paused, m_led});
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic press(int which, int len);
        if (which == 0) btn_a = 1'b0;
        else if (which == 1) btn_b = 1'b0;
        else begin btn_a = 1'b0; btn_b = 1'b0; end
        run(len);
        btn_a = 1'b1;
        btn_b = 1'b1;
        run(DC + 4);
    endtask

    initial begin
        int low, held, op;
        model_reset();
        run(3);
        check("reset", {1'b0, mode, paused, led_r, led_g, led_b}, 8'b0000_0111);
        rst_n = 1'b1;
        run(130);

        // Pause somewhere on the rising ramp, then measure the held duty.
        while (!(m_steps % (2 * MAXB) == 3 && m_phase == 0)) step();
        press(1, 12);
        check("paused", {7'b0, paused}, 8'd1);
        low = 0;
        repeat (PER) begin step(); if (!led_r) low++; end
        held = duty_of(tri_val(m_steps));
        check("pause_duty", 8'(low), 8'(held));
        run(200);
        low = 0;
        repeat (PER) begin step(); if (!led_r) low++; end
        check("pause_hold", 8'(low), 8'(held));
        press(1, 12);
        run(60);

        press(0, 5);
        check("glitch_mode", {5'b0, mode}, 8'd0);
        press(0, 12);
        check("first_press", {5'b0, mode}, 8'd1);
        repeat (4) press(0, $urandom_range(10, 20));
        check("wrap_mode", {5'b0, mode}, 8'd0);

        repeat (4) press(0, 12);
        check("cycle_mode", {5'b0, mode}, 8'd4);
        run(400);

        press(2, 14);
        run(50);

        repeat (25) begin
            op = $urandom_range(0, 4);
            case (op)
                0: press(0, $urandom_range(7, 20));
                1: press(1, $urandom_range(7, 20));
                2: press(0, $urandom_range(1, 6));
                3: press(2, $urandom_range(9, 16));
                default: run($urandom_range(1, 150));
            endcase
        end

        run($urandom_range(1, 60));
        rst_n = 1'b0;
        step();
        check("mid_reset", {1'b0, mode, paused, led_r, led_g, led_b}, 8'b0000_0111);
        rst_n = 1'b1;
        run(50);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
